learn_score_grader: RTL

Scoring stage directly downstream of the learning-mode sequencer. It watches each expected note the sequencer presents and the debounced key the player presses, and judges every note as a hit or a miss within a timing window. It tracks hit, miss and streak counters, and at song end computes a 2-bit proficiency level for the level LEDs and the character display.

---
 rtl/learn_score_grader_if.sv | 40 ++++
 rtl/learn_score_grader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/learn_score_grader_if.sv
`default_nettype none
// ============================================================================
// Module      : learn_score_grader_if
// Description : Song, note and key event inputs plus the judgement, counter
//               and grade outputs of the learning-mode score grader.
// Revision    : 1.0 - initial release
// ============================================================================
interface learn_score_grader_if #(
    parameter int CNT_W = 8
);
    logic             song_start;
    logic             song_end;
    logic             note_valid;
    logic [3:0]       expected_note;
    logic             key_valid;
    logic [3:0]       key_code;
    logic             judge_pulse;
    logic             judge_hit;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;
    logic [CNT_W-1:0] streak;
    logic [CNT_W-1:0] best_streak;
    logic [1:0]       level;
    logic             grade_valid;

    // Sequencer / key side drives events and observes the score.
    modport master (
        output song_start, song_end, note_valid, expected_note, key_valid, key_code,
        input  judge_pulse, judge_hit, hit_count, miss_count, streak, best_streak,
               level, grade_valid
    );

    // Grader side consumes events and presents the score.
    modport slave (
        input  song_start, song_end, note_valid, expected_note, key_valid, key_code,
        output judge_pulse, judge_hit, hit_count, miss_count, streak, best_streak,
               level, grade_valid
    );
endinterface
`default_nettype wire

// File: rtl/learn_score_grader.sv
`default_nettype none
// ============================================================================
// Module      : learn_score_grader
// Description : Judges each presented note as hit or miss within a timing
//               window, tracks saturating hit/miss/streak counters and grades
//               the song into a 2-bit proficiency level at song end.
//               Optional macro SCORE_WRONG_KEY_EN: a mismatching key inside
//               the window is an immediate miss (otherwise it is ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module learn_score_grader #(
    parameter int WINDOW_CYCLES = 50_000_000,   // must be >= 2
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst,
    learn_score_grader_if.slave bus
);
    // Window counter holds the number of cycles elapsed since the note_valid
    // cycle, counting that cycle itself, so it reaches WINDOW_CYCLES-1 one
    // cycle before the registered miss becomes visible.
    localparam int               c_win_w     = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [c_win_w-1:0] c_win_last  = c_win_w'(WINDOW_CYCLES - 1);
    localparam logic [c_win_w-1:0] c_win_first = c_win_w'(1);
    localparam logic [CNT_W-1:0]   c_cnt_max   = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_WINDOW = 3'd2,
        S_GRADE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [c_win_w-1:0] win_q, win_d;
    logic [3:0]         note_q, note_d;
    logic               end_pend_q, end_pend_d;   // GRADE waits one cycle for a closing miss
    logic               judge_pulse_q, judge_pulse_d;
    logic               judge_hit_q, judge_hit_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic [CNT_W-1:0]   miss_count_q, miss_count_d;
    logic [CNT_W-1:0]   streak_q, streak_d;
    logic [CNT_W-1:0]   best_streak_q, best_streak_d;
    logic [1:0]         level_q, level_d;
    logic               grade_valid_q, grade_valid_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_cnt_max) ? v : v + 1'b1;
    endfunction

    logic [CNT_W:0]   w_total;
    logic [CNT_W+3:0] w_hit8, w_hit4, w_hit2, w_tot7, w_tot3, w_tot1;
    logic [1:0]       w_level;

    // Proficiency thresholds 7/8, 3/4, 1/2 evaluated on the saturated counts.
    always_comb begin
        w_total = {1'b0, hit_count_q} + {1'b0, miss_count_q};
        w_hit8  = {1'b0, hit_count_q, 3'b000};
        w_hit4  = {2'b00, hit_count_q, 2'b00};
        w_hit2  = {3'b000, hit_count_q, 1'b0};
        w_tot7  = {w_total, 3'b000} - {3'b000, w_total};
        w_tot3  = {2'b00, w_total, 1'b0} + {3'b000, w_total};
        w_tot1  = {3'b000, w_total};
        if (w_total == '0)          w_level = 2'd0;
        else if (w_hit8 >= w_tot7)  w_level = 2'd3;
        else if (w_hit4 >= w_tot3)  w_level = 2'd2;
        else if (w_hit2 >= w_tot1)  w_level = 2'd1;
        else                        w_level = 2'd0;
    end

    logic             w_key_match, w_key_wrong, w_timeout, w_judge;
    logic [CNT_W-1:0] w_streak_inc;

    // Window closing events for the currently open note.
    always_comb begin
        w_key_match  = bus.key_valid && (bus.key_code == note_q);
`ifdef SCORE_WRONG_KEY_EN
        w_key_wrong  = bus.key_valid && !w_key_match;
`else
        w_key_wrong  = 1'b0;
`endif
        w_timeout    = (win_q == c_win_last);
        w_judge      = w_key_match || w_key_wrong || w_timeout
                       || bus.note_valid || bus.song_end;
        w_streak_inc = sat_inc(streak_q);
    end

    // Next-state and next-output logic; song_start overrides everything.
    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        note_d        = note_q;
        end_pend_d    = end_pend_q;
        judge_pulse_d = 1'b0;
        judge_hit_d   = judge_hit_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        streak_d      = streak_q;
        best_streak_d = best_streak_q;
        level_d       = level_q;
        grade_valid_d = grade_valid_q;

        if (bus.song_start) begin
            state_d       = S_ARMED;
            end_pend_d    = 1'b0;
            judge_hit_d   = 1'b0;
            hit_count_d   = '0;
            miss_count_d  = '0;
            streak_d      = '0;
            best_streak_d = '0;
            level_d       = 2'd0;
            grade_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_ARMED: begin
                    if (bus.song_end) begin
                        state_d = S_GRADE;
                    end else if (bus.note_valid) begin
                        note_d  = bus.expected_note;
                        win_d   = c_win_first;
                        state_d = S_WINDOW;
                    end
                end
                S_WINDOW: begin
                    win_d = win_q + 1'b1;
                    if (w_judge) begin
                        // A matching key wins over timeout, new note or song end.
                        judge_pulse_d = 1'b1;
                        judge_hit_d   = w_key_match;
                        if (w_key_match) begin
                            hit_count_d   = sat_inc(hit_count_q);
                            streak_d      = w_streak_inc;
                            best_streak_d = (w_streak_inc > best_streak_q) ? w_streak_inc
                                                                           : best_streak_q;
                        end else begin
                            miss_count_d  = sat_inc(miss_count_q);
                            streak_d      = '0;
                        end
                        if (bus.song_end) begin
                            state_d    = S_GRADE;
                            end_pend_d = 1'b1;
                        end else if (bus.note_valid) begin
                            note_d = bus.expected_note;
                            win_d  = c_win_first;
                        end else begin
                            state_d = S_ARMED;
                        end
                    end
                end
                S_GRADE: begin
                    if (end_pend_q) begin
                        end_pend_d = 1'b0;
                    end else begin
                        level_d       = w_level;
                        grade_valid_d = 1'b1;
                        state_d       = S_DONE;
                    end
                end
                S_DONE: begin
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            win_q         <= '0;
            note_q        <= '0;
            end_pend_q    <= 1'b0;
            judge_pulse_q <= 1'b0;
            judge_hit_q   <= 1'b0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
            streak_q      <= '0;
            best_streak_q <= '0;
            level_q       <= 2'd0;
            grade_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            note_q        <= note_d;
            end_pend_q    <= end_pend_d;
            judge_pulse_q <= judge_pulse_d;
            judge_hit_q   <= judge_hit_d;
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
            streak_q      <= streak_d;
            best_streak_q <= best_streak_d;
            level_q       <= level_d;
            grade_valid_q <= grade_valid_d;
        end
    end

    assign bus.judge_pulse = judge_pulse_q;
    assign bus.judge_hit   = judge_hit_q;
    assign bus.hit_count   = hit_count_q;
    assign bus.miss_count  = miss_count_q;
    assign bus.streak      = streak_q;
    assign bus.best_streak = best_streak_q;
    assign bus.level       = level_q;
    assign bus.grade_valid = grade_valid_q;

endmodule
`default_nettype wire
